// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel filter.
// Output modes, FSM state codes and kernel width helper.
package sobel_pkg;

  localparam int MODE_MAG = 0;
  localparam int MODE_GX  = 1;
  localparam int MODE_GY  = 2;
  localparam int MODE_THR = 3;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  function automatic int ksum_w(input int pw);
    return pw + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of delay, advancing only on accepted pixels.
// Storage is never cleared; only the pointer resets.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int DEPTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (en)
      mem[ptr] <= din;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter, one result per input pixel.
// Window column = {row r-1, row r, row r+1} from two cascaded line buffers.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int OUT_W  = 32,
  parameter int MODE   = 0,
  parameter int THRESH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PIX_W-1:0]        s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_last
);

  localparam int KW = ksum_w(PIX_W);
  localparam int MW = KW + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  function automatic logic signed [KW-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  logic [1:0]       state;
  logic [CW-1:0]    in_c, out_c;
  logic [RW-1:0]    in_r, out_r;
  logic [PIX_W-1:0] lb0, lb1;
  logic [PIX_W-1:0] p [3][3];
  logic [PIX_W-1:0] w [3][3];

  logic accept, load, load_run, load_flush;
  logic in_last, in_fill_done, out_last, border;
  logic signed [KW-1:0]    gx, gy;
  logic [KW-1:0]           ax, ay;
  logic [MW-1:0]           mag;
  logic signed [OUT_W-1:0] res;

  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      FILL:    s_ready = 1'b1;
      RUN:     s_ready = !m_valid || m_ready;
      default: s_ready = 1'b0;
    endcase
  end

  assign accept = s_valid && s_ready;

  sobel_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rst(rst), .en(accept), .din(s_data), .dout(lb0)
  );

  sobel_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst(rst), .en(accept), .din(lb0), .dout(lb1)
  );

  // Window as it will look after this accept; results register on the same edge.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w[i][0] = p[i][1];
      w[i][1] = p[i][2];
    end
    w[0][2] = lb1;
    w[1][2] = lb0;
    w[2][2] = s_data;
  end

  always_ff @(posedge clk) begin
    if (accept)
      p <= w;
  end

  assign gx = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
            - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
  assign gy = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
            - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));

  assign ax  = gx[KW-1] ? KW'(-gx) : KW'(gx);
  assign ay  = gy[KW-1] ? KW'(-gy) : KW'(gy);
  assign mag = MW'(ax) + MW'(ay);

  assign border = (out_r == '0) || (out_r == RW'(IMG_H - 1))
               || (out_c == '0) || (out_c == CW'(IMG_W - 1));

  always_comb begin
    res = '0;
    if (!border) begin
      case (MODE)
        MODE_GX:  res = OUT_W'(gx);
        MODE_GY:  res = OUT_W'(gy);
        MODE_THR: res = (32'(mag) >= 32'(THRESH)) ? OUT_W'({PIX_W{1'b1}}) : '0;
        default:  res = OUT_W'(mag);
      endcase
    end
  end

  assign in_last      = (in_r == RW'(IMG_H - 1)) && (in_c == CW'(IMG_W - 1));
  assign in_fill_done = (in_r == RW'(1)) && (in_c == '0);
  assign out_last     = (out_r == RW'(IMG_H - 1)) && (out_c == CW'(IMG_W - 1));

  assign load_run   = accept && (state == RUN);
  assign load_flush = (state == FLUSH) && (!m_valid || m_ready)
                   && !(m_valid && m_last);
  assign load       = load_run || load_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      in_c    <= '0;
      in_r    <= '0;
      out_c   <= '0;
      out_r   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (in_c == CW'(IMG_W - 1)) begin
          in_c <= '0;
          in_r <= (in_r == RW'(IMG_H - 1)) ? '0 : in_r + RW'(1);
        end else begin
          in_c <= in_c + CW'(1);
        end
      end
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_flush ? '0 : res;
        m_last  <= out_last;
        if (out_c == CW'(IMG_W - 1)) begin
          out_c <= '0;
          out_r <= (out_r == RW'(IMG_H - 1)) ? '0 : out_r + RW'(1);
        end else begin
          out_c <= out_c + CW'(1);
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      unique case (state)
        FILL:    if (accept && in_fill_done) state <= RUN;
        RUN:     if (accept && in_last) state <= FLUSH;
        FLUSH:   if (m_valid && m_ready && m_last) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench: 5x4 frames on one instance, 100x100 step image on five mode variants.
module tb_sobel_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic sv_a, sr_a, mv_a, mr_a, ml_a;
  logic [7:0] sd_a;
  logic signed [31:0] md_a;

  logic sv_b, mr_b;
  logic [7:0] sd_b;
  logic [4:0] sr_b, mv_b, ml_b;
  logic signed [31:0] md_b [5];

  sobel_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(4), .OUT_W(32), .MODE(0), .THRESH(128)) dut_a (
    .clk(clk), .rst(rst), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a),
    .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .m_last(ml_a)
  );

  sobel_stream #(.PIX_W(8), .IMG_W(100), .IMG_H(100), .OUT_W(32), .MODE(0), .THRESH(128)) dut_b0 (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b[0]), .s_data(sd_b),
    .m_valid(mv_b[0]), .m_ready(mr_b), .m_data(md_b[0]), .m_last(ml_b[0])
  );
  sobel_stream #(.PIX_W(8), .IMG_W(100), .IMG_H(100), .OUT_W(32), .MODE(1), .THRESH(128)) dut_b1 (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b[1]), .s_data(sd_b),
    .m_valid(mv_b[1]), .m_ready(mr_b), .m_data(md_b[1]), .m_last(ml_b[1])
  );
  sobel_stream #(.PIX_W(8), .IMG_W(100), .IMG_H(100), .OUT_W(32), .MODE(2), .THRESH(128)) dut_b2 (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b[2]), .s_data(sd_b),
    .m_valid(mv_b[2]), .m_ready(mr_b), .m_data(md_b[2]), .m_last(ml_b[2])
  );
  sobel_stream #(.PIX_W(8), .IMG_W(100), .IMG_H(100), .OUT_W(32), .MODE(3), .THRESH(400)) dut_b3 (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b[3]), .s_data(sd_b),
    .m_valid(mv_b[3]), .m_ready(mr_b), .m_data(md_b[3]), .m_last(ml_b[3])
  );
  sobel_stream #(.PIX_W(8), .IMG_W(100), .IMG_H(100), .OUT_W(32), .MODE(3), .THRESH(401)) dut_b4 (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b[4]), .s_data(sd_b),
    .m_valid(mv_b[4]), .m_ready(mr_b), .m_data(md_b[4]), .m_last(ml_b[4])
  );

  int tests = 0;
  int fails = 0;
  int timeouts = 0;

  logic signed [31:0] qa_d [$];
  logic               qa_l [$];
  int                 unstable_a = 0;
  int                 lastcnt_a = 0;
  logic               held_a = 1'b0;
  logic signed [31:0] hd_a = '0;
  logic               hl_a = 1'b0;

  logic signed [31:0] qb [5][$];
  logic               ql_b0 [$];

  string bname [5] = '{"b_mag", "b_gx", "b_gy", "b_thr400", "b_thr401"};

  // Transfers happen at the posedge after each negedge where valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (held_a && (!mv_a || md_a !== hd_a || ml_a !== hl_a))
        unstable_a <= unstable_a + 1;
      if (mv_a && mr_a) begin
        qa_d.push_back(md_a);
        qa_l.push_back(ml_a);
        if (ml_a)
          lastcnt_a <= lastcnt_a + 1;
      end
    end
    held_a <= mv_a && !mr_a && !rst;
    hd_a   <= md_a;
    hl_a   <= ml_a;
  end

  always @(negedge clk) begin
    if (!rst && mr_b) begin
      for (int i = 0; i < 5; i++)
        if (mv_b[i])
          qb[i].push_back(md_b[i]);
      if (mv_b[0])
        ql_b0.push_back(ml_b[0]);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_small(input int kind, input bit stall, input int npix, input int nexp);
    int base;
    int guard;
    int idx;
    base = qa_d.size();
    for (int n = 0; n < npix; n++) begin
      idx  = n % 20;
      sv_a = 1'b1;
      sd_a = (kind == 1) ? 8'(idx) : 8'd77;
      guard = 0;
      @(negedge clk);
      while (!sr_a && guard < 300) begin
        @(posedge clk); #1;
        mr_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        guard++;
      end
      if (guard >= 300)
        timeouts++;
      @(posedge clk); #1;
      mr_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    sv_a = 1'b0;
    guard = 0;
    while (qa_d.size() - base < nexp && guard < 1000) begin
      @(posedge clk); #1;
      mr_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      guard++;
    end
    if (guard >= 1000)
      timeouts++;
    mr_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Ramp r*5+c: interior |Gx|=8, |Gy|=40, so 48; constant frame gives 0 everywhere.
  task automatic check_small(input int kind, input int base, input int nf);
    int idx, r, c;
    logic signed [31:0] e;
    chk("a_count", qa_d.size() - base, 20 * nf);
    for (int k = 0; k < 20 * nf; k++) begin
      if (base + k < qa_d.size()) begin
        idx = k % 20;
        r = idx / 5;
        c = idx % 5;
        e = (kind == 1 && r >= 1 && r <= 2 && c >= 1 && c <= 3) ? 32'sd48 : 32'sd0;
        chk("a_data", qa_d[base + k], e);
        chk("a_last", qa_l[base + k], (idx == 19) ? 1 : 0);
      end
    end
  endtask

  task automatic run_big(input bit inv);
    int base;
    int guard;
    int c;
    base = qb[0].size();
    for (int n = 0; n < 10000; n++) begin
      c = n % 100;
      sv_b = 1'b1;
      sd_b = ((c >= 50) != inv) ? 8'd100 : 8'd0;
      guard = 0;
      @(negedge clk);
      while (!sr_b[0] && guard < 300) begin
        @(posedge clk); #1;
        @(negedge clk);
        guard++;
      end
      if (guard >= 300)
        timeouts++;
      @(posedge clk); #1;
    end
    sv_b = 1'b0;
    guard = 0;
    while (qb[0].size() - base < 10000 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000)
      timeouts++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Step at col 50: interior cols 49/50 see Gx=+-400, Gy=0.
  task automatic check_big(input bit inv, input int base);
    int r, c;
    bit edge_px;
    logic signed [31:0] e [5];
    for (int i = 0; i < 5; i++)
      chk("b_count", qb[i].size() - base, 10000);
    for (int k = 0; k < 10000; k++) begin
      r = k / 100;
      c = k % 100;
      edge_px = (r >= 1 && r <= 98 && (c == 49 || c == 50));
      e[0] = edge_px ? 32'sd400 : 32'sd0;
      e[1] = edge_px ? (inv ? -32'sd400 : 32'sd400) : 32'sd0;
      e[2] = 32'sd0;
      e[3] = edge_px ? 32'sd255 : 32'sd0;
      e[4] = 32'sd0;
      for (int i = 0; i < 5; i++)
        if (base + k < qb[i].size())
          chk(bname[i], qb[i][base + k], e[i]);
      if (base + k < ql_b0.size())
        chk("b_last", ql_b0[base + k], (k == 9999) ? 1 : 0);
    end
  endtask

  initial begin
    int b0, b1, lc;
    rst  = 1'b1;
    sv_a = 1'b0;
    sd_a = '0;
    mr_a = 1'b1;
    sv_b = 1'b0;
    sd_b = '0;
    mr_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", mv_a, 0);
    chk("rst_m_data", md_a, 0);
    chk("rst_m_last", ml_a, 0);
    chk("rst_s_ready", sr_a, 1);
    chk("rst_b_m_valid", mv_b, 0);
    chk("rst_b_s_ready", sr_b, 5'b11111);
    @(posedge clk); #1;

    b0 = qa_d.size();
    run_small(0, 1'b0, 20, 20);
    check_small(0, b0, 1);

    b0 = qa_d.size();
    run_small(1, 1'b0, 20, 20);
    check_small(1, b0, 1);

    b0 = qa_d.size();
    run_small(1, 1'b1, 20, 20);
    check_small(1, b0, 1);
    chk("stall_stable", unstable_a, 0);

    run_small(1, 1'b0, 9, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_m_valid", mv_a, 0);
    chk("abort_s_ready", sr_a, 1);
    @(posedge clk); #1;

    b0 = qa_d.size();
    run_small(1, 1'b0, 20, 20);
    check_small(1, b0, 1);

    lc = lastcnt_a;
    b0 = qa_d.size();
    run_small(1, 1'b1, 40, 40);
    check_small(1, b0, 2);
    chk("two_last", lastcnt_a - lc, 2);
    chk("stall_stable2", unstable_a, 0);

    b1 = qb[0].size();
    run_big(1'b0);
    check_big(1'b0, b1);

    b1 = qb[0].size();
    run_big(1'b1);
    check_big(1'b1, b1);

    chk("timeouts", timeouts, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
